// File: rtl/barrel_collision.sv
// Player/barrel collision, lives and invulnerability tracking, and jump-over scoring.
// All state updates on the rising frame clock; every output is registered.
module barrel_collision #(
    parameter int unsigned LIVES_INIT = 3,
    parameter int unsigned INV_FRAMES = 60,
    parameter int unsigned JUMP_WIN   = 40,
    parameter int unsigned POINTS     = 100
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        pause,
    input  logic        enter,
    input  logic [9:0]  PlayerX,
    input  logic [9:0]  PlayerY,
    input  logic [9:0]  PlayerS,
    input  logic [39:0] BarrelX,
    input  logic [39:0] BarrelY,
    input  logic [39:0] BarrelS,
    input  logic [3:0]  barrel_en,
    output logic        hit,
    output logic [2:0]  lives,
    output logic        invuln,
    output logic        game_over,
    output logic [15:0] score
);
    localparam int unsigned NB    = 4;
    localparam int unsigned CW    = 11;
    localparam int unsigned SW    = 12;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] INV_LOAD  = (INV_FRAMES == 0) ? CNT_W'(1) : CNT_W'(INV_FRAMES);
    localparam logic [2:0]       LIVES_RST = 3'(LIVES_INIT);
    localparam logic signed [SW-1:0] JW    = $signed(SW'(JUMP_WIN));

    typedef enum logic [1:0] {PLAY, HIT, OVER} state_t;

    state_t            state, state_n;
    logic [2:0]        lives_n;
    logic [CNT_W-1:0]  inv_cnt, inv_cnt_n;
    logic [NB-1:0]     latch, latch_n;
    logic              hit_n, invuln_n, game_over_n;
    logic [15:0]       score_n;

    logic [NB-1:0]     overlap, jump, clr, fresh;
    logic [2:0]        fresh_cnt;
    logic [31:0]       sum;

    // Per-barrel geometry: overlap, clean jump-over, and latch-release conditions.
    always_comb begin
        logic [CW-1:0] px, py, ps, bx, by, bs, dx, dy, r;
        logic [SW-1:0] pbot;
        logic signed [SW-1:0] btop, rise;
        overlap = '0;
        jump    = '0;
        clr     = '0;
        px = CW'(PlayerX);
        py = CW'(PlayerY);
        ps = CW'(PlayerS);
        bx = '0; by = '0; bs = '0; dx = '0; dy = '0; r = '0;
        pbot = '0; btop = '0; rise = '0;
        for (int i = 0; i < NB; i++) begin
            bx = CW'(BarrelX[10*i +: 10]);
            by = CW'(BarrelY[10*i +: 10]);
            bs = CW'(BarrelS[10*i +: 10]);
            dx = (px >= bx) ? px - bx : bx - px;
            dy = (py >= by) ? py - by : by - py;
            r  = ps + bs;
            pbot = SW'(py) + SW'(ps);
            btop = $signed(SW'(by)) - $signed(SW'(bs));
            rise = $signed(SW'(by)) - $signed(SW'(py));
            overlap[i] = barrel_en[i] && (dx < r) && (dy < r);
            jump[i]    = barrel_en[i] && (dx < r) && !btop[SW-1]
                         && (pbot <= SW'(btop)) && (rise <= JW);
            clr[i]     = !barrel_en[i] || (dx >= r);
        end
    end

    // Points for barrels newly cleared this frame, saturating at 16 bits.
    always_comb begin
        fresh     = jump & ~latch;
        fresh_cnt = '0;
        for (int i = 0; i < NB; i++) begin
            fresh_cnt = fresh_cnt + 3'(fresh[i]);
        end
        sum = 32'(score) + 32'(fresh_cnt) * 32'(POINTS);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n     = state;
        lives_n     = lives;
        inv_cnt_n   = inv_cnt;
        latch_n     = latch;
        score_n     = score;
        hit_n       = 1'b0;
        if (pause) begin
            if (enter) begin
                state_n   = PLAY;
                lives_n   = LIVES_RST;
                inv_cnt_n = '0;
                latch_n   = '0;
                score_n   = '0;
            end
        end else begin
            case (state)
                PLAY: begin
                    latch_n = (latch | jump) & ~clr;
                    if (|overlap) begin
                        hit_n = 1'b1;
                        if (lives <= 3'd1) begin
                            state_n = OVER;
                            lives_n = '0;
                        end else begin
                            state_n   = HIT;
                            lives_n   = lives - 3'd1;
                            inv_cnt_n = INV_LOAD;
                        end
                    end else begin
                        score_n = (sum > 32'hFFFF) ? 16'hFFFF : sum[15:0];
                    end
                end
                HIT: begin
                    latch_n = (latch | jump) & ~clr;
                    score_n = (sum > 32'hFFFF) ? 16'hFFFF : sum[15:0];
                    if (inv_cnt <= CNT_W'(1)) begin
                        state_n   = PLAY;
                        inv_cnt_n = '0;
                    end else begin
                        inv_cnt_n = inv_cnt - CNT_W'(1);
                    end
                end
                OVER: ;
                default: state_n = PLAY;
            endcase
        end
        invuln_n    = (state_n == HIT);
        game_over_n = (state_n == OVER);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state     <= PLAY;
            lives     <= LIVES_RST;
            inv_cnt   <= '0;
            latch     <= '0;
            score     <= '0;
            hit       <= 1'b0;
            invuln    <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_n;
            lives     <= lives_n;
            inv_cnt   <= inv_cnt_n;
            latch     <= latch_n;
            score     <= score_n;
            hit       <= hit_n;
            invuln    <= invuln_n;
            game_over <= game_over_n;
        end
    end
endmodule

// File: tb/tb_barrel_collision.sv
// Scoreboard bench for barrel_collision: the driver queues hand-derived expectations per frame,
// and a monitor pops and compares them one step after each rising edge.
module tb_barrel_collision;
    logic        frame_clk;
    logic        Reset;
    logic        pause;
    logic        enter;
    logic [9:0]  PlayerX, PlayerY, PlayerS;
    logic [39:0] BarrelX, BarrelY, BarrelS;
    logic [3:0]  barrel_en;
    logic        hit;
    logic [2:0]  lives;
    logic        invuln;
    logic        game_over;
    logic [15:0] score;

    typedef struct {
        logic        h;
        logic [2:0]  l;
        logic        iv;
        logic        go;
        logic [15:0] s;
        logic        iv_x;
        string       name;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    barrel_collision dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .pause     (pause),
        .enter     (enter),
        .PlayerX   (PlayerX),
        .PlayerY   (PlayerY),
        .PlayerS   (PlayerS),
        .BarrelX   (BarrelX),
        .BarrelY   (BarrelY),
        .BarrelS   (BarrelS),
        .barrel_en (barrel_en),
        .hit       (hit),
        .lives     (lives),
        .invuln    (invuln),
        .game_over (game_over),
        .score     (score)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    function automatic exp_t ex(input logic h, input logic [2:0] l, input logic iv,
                                input logic go, input logic [15:0] s, input string n,
                                input logic ix = 1'b0);
        exp_t e;
        e.h = h; e.l = l; e.iv = iv; e.go = go; e.s = s; e.name = n; e.iv_x = ix;
        return e;
    endfunction

    task automatic compare(input exp_t e);
        checks++;
        if (hit !== e.h || lives !== e.l || game_over !== e.go || score !== e.s ||
            (!e.iv_x && invuln !== e.iv)) begin
            errors++;
            $display("FAIL %s: got hit=%0d lives=%0d invuln=%0d game_over=%0d score=%0d, want hit=%0d lives=%0d invuln=%0d%s game_over=%0d score=%0d",
                     e.name, hit, lives, invuln, game_over, score,
                     e.h, e.l, e.iv, e.iv_x ? "(any)" : "", e.go, e.s);
        end
    endtask

    // Monitor: the DUT presents a fresh output set after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                compare(e);
            end
        end
    end

    task automatic step(input exp_t e);
        q.push_back(e);
        @(posedge frame_clk);
        @(negedge frame_clk);
    endtask

    task automatic put_barrel(input int i, input int x, input int y, input int s);
        BarrelX[10*i +: 10] = 10'(x);
        BarrelY[10*i +: 10] = 10'(y);
        BarrelS[10*i +: 10] = 10'(s);
    endtask

    task automatic put_player(input int x, input int y, input int s);
        PlayerX = 10'(x);
        PlayerY = 10'(y);
        PlayerS = 10'(s);
    endtask

    initial begin
        int s_exp;
        Reset = 1'b1; pause = 1'b0; enter = 1'b0;
        BarrelX = '0; BarrelY = '0; BarrelS = '0;
        put_player(300, 300, 12);
        put_barrel(0, 300, 300, 12);
        for (int i = 1; i < 4; i++) put_barrel(i, 600, 600, 12);
        barrel_en = 4'b0001;

        @(negedge frame_clk);
        compare(ex(0, 3, 0, 0, 0, "reset_state"));
        Reset = 1'b0;

        // Overlap held through invulnerability.
        step(ex(1, 2, 1, 0, 0, "first_hit"));
        for (int k = 2; k <= 61; k++) step(ex(0, 2, (k <= 60), 0, 0, "inv_window"));
        step(ex(1, 1, 1, 0, 0, "rehit_after_inv"));
        step(ex(0, 1, 1, 0, 0, "inv_run"));
        step(ex(0, 1, 1, 0, 0, "inv_run"));

        // Freeze mid-invulnerability; the window must resume where it stopped.
        pause = 1'b1;
        for (int k = 0; k < 5; k++) step(ex(0, 1, 1, 0, 0, "pause_hold"));
        pause = 1'b0;
        for (int j = 1; j <= 58; j++) step(ex(0, 1, (j < 58), 0, 0, "inv_resume"));
        step(ex(1, 0, 0, 1, 0, "fatal_hit"));
        for (int k = 0; k < 3; k++) step(ex(0, 0, 0, 1, 0, "over_ignores"));

        pause = 1'b1; enter = 1'b1;
        step(ex(0, 3, 0, 0, 0, "restart"));
        pause = 1'b0; enter = 1'b0;

        // Jump-over scoring with latch release.
        put_player(200, 150, 12);
        put_barrel(0, 205, 190, 12);
        step(ex(0, 3, 0, 0, 100, "jump_score"));
        step(ex(0, 3, 0, 0, 100, "jump_held"));
        put_barrel(0, 240, 190, 12);
        step(ex(0, 3, 0, 0, 100, "jump_released"));
        put_barrel(0, 205, 190, 12);
        step(ex(0, 3, 0, 0, 200, "jump_again"));

        put_barrel(0, 224, 150, 12);
        step(ex(0, 3, 0, 0, 200, "touch_no_hit"));

        // Hit and jump in the same frame: hit wins, latch still set.
        put_barrel(0, 200, 150, 12);
        put_barrel(1, 205, 190, 12);
        barrel_en = 4'b0011;
        step(ex(1, 2, 1, 0, 200, "hit_beats_jump"));
        step(ex(0, 2, 1, 0, 200, "latched_in_hit"));
        put_barrel(1, 240, 190, 12);
        step(ex(0, 2, 1, 0, 200, "release_in_hit"));
        put_barrel(1, 205, 190, 12);
        step(ex(0, 2, 1, 0, 300, "score_in_hit"));

        put_barrel(0, 400, 190, 12);
        put_barrel(1, 400, 190, 12);
        step(ex(0, 2, 1, 0, 300, "both_away"));
        put_barrel(0, 205, 190, 12);
        put_barrel(1, 195, 190, 12);
        step(ex(0, 2, 1, 0, 500, "two_jumps"));

        put_barrel(0, 400, 190, 12);
        put_barrel(1, 400, 190, 12);
        for (int k = 0; k < 60; k++) step(ex(0, 2, 0, 0, 500, "wait_inv", 1'b1));

        // Four barrels per jump frame drive the score into saturation.
        barrel_en = 4'b1111;
        s_exp = 500;
        for (int n = 0; n < 170; n++) begin
            for (int i = 0; i < 4; i++) put_barrel(i, 205, 190, 12);
            s_exp = (s_exp + 400 > 65535) ? 65535 : s_exp + 400;
            step(ex(0, 2, 0, 0, 16'(s_exp), "multi_jump"));
            for (int i = 0; i < 4; i++) put_barrel(i, 400, 190, 12);
            step(ex(0, 2, 0, 0, 16'(s_exp), "multi_away"));
        end
        for (int i = 0; i < 4; i++) put_barrel(i, 205, 190, 12);
        step(ex(0, 2, 0, 0, 16'hFFFF, "saturated"));

        pause = 1'b1; enter = 1'b1;
        step(ex(0, 3, 0, 0, 0, "restart_clears_score"));
        pause = 1'b0; enter = 1'b0;

        // Async reset in the middle of invulnerability.
        for (int i = 1; i < 4; i++) put_barrel(i, 600, 600, 12);
        barrel_en = 4'b0001;
        put_barrel(0, 205, 190, 12);
        step(ex(0, 3, 0, 0, 100, "pre_reset_score"));
        put_barrel(0, 200, 150, 12);
        step(ex(1, 2, 1, 0, 100, "pre_reset_hit"));
        step(ex(0, 2, 1, 0, 100, "pre_reset_inv"));
        Reset = 1'b1;
        #1;
        compare(ex(0, 3, 0, 0, 0, "async_reset"));
        @(posedge frame_clk);
        @(negedge frame_clk);
        Reset = 1'b0;

        repeat (3) @(posedge frame_clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
